bias_add_pipe: RTL and testbench
================================

BIAS_ADD_PIPE -- requirements
Module: bias_add_pipe

Interface
REQ-001 Parameter DATA_LEN, default 18: two's-complement width of each activation and bias word.
REQ-002 Parameter CH, default 32: channels per beat; bias index = channel.
REQ-003 Parameter POS, default 12: positions per channel per beat; word k = CH index i, POS index j, k = POS*i+j.
REQ-004 Parameter LAYERS, default 5: number of bias banks; LW = clog2(LAYERS), AW = clog2(LAYERS*CH).
REQ-005 clk  input  1  sole clock, all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  input beat present.
REQ-008 in_ready  output  1  block accepts beat this cycle.
REQ-009 layer_sel  input  LW  bias bank for the beat, sampled with the beat.
REQ-010 d  input  CH*POS*DATA_LEN  activations, word k at bits [k*DATA_LEN +: DATA_LEN].
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 q  output  CH*POS*DATA_LEN  results, same packing as d.
REQ-014 sat_en  input  1  1 = saturate, 0 = wrap (sampled with beat).
REQ-015 relu_en  input  1  1 = clamp negative results to 0 (sampled with beat).
REQ-016 bw_en / bw_addr(AW) / bw_data(DATA_LEN)  input  bias write port; address = layer*CH + channel.
REQ-017 ovf  output  1  sticky: some saturated word since last clear.
REQ-018 sel_err  output  1  sticky: beat accepted with layer_sel >= LAYERS.
REQ-019 flag_clr  input  1  clears ovf and sel_err.

Function
REQ-020 Beat accepted when in_valid && in_ready; result transferred when out_valid && out_ready.
REQ-021 Two-stage pipeline: stage 1 registers d, bias word of channel i, mode bits; stage 2 registers q.
REQ-022 Latency accept-to-out_valid is exactly 2 cycles with out_ready held high; throughput 1 beat/cycle.
REQ-023 in_ready = !(stage-1 valid && stage-2 valid && !out_ready); no beat dropped or duplicated.
REQ-024 While out_valid && !out_ready, q and out_valid hold stable.
REQ-025 Sum computed at DATA_LEN+1 bits: s = sext(d_k) + sext(bias[layer*CH+i]).
REQ-026 sat_en=1: s > 2^(DATA_LEN-1)-1 -> max positive, s < -2^(DATA_LEN-1) -> most negative, ovf set; sat_en=0: low DATA_LEN bits of s, ovf untouched.
REQ-027 relu_en=1: negative result (after saturate/wrap) -> 0.
REQ-028 layer_sel >= LAYERS: bias treated as 0 for that beat, sel_err set.
REQ-029 Bias write at cycle t is visible to beats accepted at t+1 or later; beat accepted at t uses old value (read-before-write).
REQ-030 bw_addr >= LAYERS*CH: write ignored.
REQ-031 flag_clr and a same-cycle set event: set wins.
REQ-032 Bias writes are accepted regardless of in/out handshake state.

Reset
REQ-033 On rst: out_valid=0, q=0, stage valids=0, ovf=0, sel_err=0, all bias words=0; in_ready=1 first cycle after rst deasserts.
REQ-034 rst mid-stream discards in-flight beats; no out_valid for them after reset.
REQ-035 rst overrides bw_en and flag_clr in the same cycle.

Structure
REQ-036 DATA_LEN default, layer index constants (LAYER0..LAYER3, AFFINE = 4) and saturation helper functions live in the shared package/include used by the layer datapath.
REQ-037 One sub-module, sat_relu_word: single-word DATA_LEN+1 -> DATA_LEN saturate/wrap + ReLU + overflow flag, instantiated CH*POS times.

Verification
REQ-038 Write bias[1*CH+3]=5, layer_sel=1, d all 10, sat_en=0 -> channel-3 words 15, others 10, out_valid 2 cycles after accept.
REQ-039 DATA_LEN=18, d=131000, bias=200, sat_en=1 -> q=131071, ovf=1; same with sat_en=0 -> q=-130944, ovf stays as before.
REQ-040 d=-50, bias=20, relu_en=1 -> q=0; relu_en=0 -> q=-30.
REQ-041 Continuous in_valid, out_ready toggled 1/0 each cycle -> outputs in order, no loss, q stable during stall, in_ready low only when both stages full.
REQ-042 bw_en and accept same cycle for that address -> beat uses old bias, next beat uses new.
REQ-043 layer_sel=7 with LAYERS=5 -> q=d, sel_err=1; flag_clr -> sel_err=0; rst during full pipeline -> out_valid=0 next cycle, bias reads 0.

Source files
------------

// File: rtl/bias_add_pipe_pkg.sv
// Shared constants and word-level helpers for the bias-add datapath.
package bias_add_pipe_pkg;

    localparam int unsigned DATA_LEN_DEF = 18;

    localparam int unsigned LAYER0 = 0;
    localparam int unsigned LAYER1 = 1;
    localparam int unsigned LAYER2 = 2;
    localparam int unsigned LAYER3 = 3;
    localparam int unsigned AFFINE = 4;

    // top = two MSBs of a sum one bit wider than the result word
    function automatic logic sum_overflows(input logic [1:0] top);
        return top[1] ^ top[0];
    endfunction

    function automatic logic relu_zero(input logic sign, input logic en);
        return sign & en;
    endfunction

endpackage

// File: rtl/bias_add_pipe_sat_relu_word.sv
// One result word: (DATA_LEN+1)-bit sum -> DATA_LEN bits via saturate or wrap, then optional ReLU.
module sat_relu_word
    import bias_add_pipe_pkg::*;
#(
    parameter int unsigned DATA_LEN = DATA_LEN_DEF
) (
    input  logic [DATA_LEN:0]   s,
    input  logic                sat_en,
    input  logic                relu_en,
    output logic [DATA_LEN-1:0] y,
    output logic                ovf
);

    logic                wide;
    logic [DATA_LEN-1:0] clip;

    assign wide = sum_overflows(s[DATA_LEN -: 2]);
    assign ovf  = sat_en && wide;

    always_comb begin
        clip = s[DATA_LEN-1:0];
        if (sat_en && wide) begin
            // s[DATA_LEN] is the true sign of the unsaturated sum
            clip = s[DATA_LEN] ? {1'b1, {(DATA_LEN-1){1'b0}}} : {1'b0, {(DATA_LEN-1){1'b1}}};
        end
        y = relu_zero(clip[DATA_LEN-1], relu_en) ? '0 : clip;
    end

endmodule

// File: rtl/bias_add_pipe.sv
// Two-stage per-channel bias add with banked bias RAM, saturate/wrap, ReLU and sticky flags.
module bias_add_pipe
    import bias_add_pipe_pkg::*;
#(
    parameter int unsigned DATA_LEN = DATA_LEN_DEF,
    parameter int unsigned CH       = 32,
    parameter int unsigned POS      = 12,
    parameter int unsigned LAYERS   = 5,
    localparam int unsigned LW      = (LAYERS > 1) ? $clog2(LAYERS) : 1,
    localparam int unsigned AW      = (LAYERS * CH > 1) ? $clog2(LAYERS * CH) : 1,
    localparam int unsigned DW      = CH * POS * DATA_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LW-1:0]       layer_sel,
    input  logic [DW-1:0]       d,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       q,
    input  logic                sat_en,
    input  logic                relu_en,
    input  logic                bw_en,
    input  logic [AW-1:0]       bw_addr,
    input  logic [DATA_LEN-1:0] bw_data,
    output logic                ovf,
    output logic                sel_err,
    input  logic                flag_clr
);

    logic [DATA_LEN-1:0]    bias_mem [LAYERS*CH];
    logic [CH*DATA_LEN-1:0] bias_rd;
    logic                   layer_ok;
    logic                   accept;
    logic                   s2_en;

    logic                   s1_valid;
    logic [DW-1:0]          s1_d;
    logic [CH*DATA_LEN-1:0] s1_bias;
    logic                   s1_sat;
    logic                   s1_relu;

    logic [DW-1:0]          res;
    logic [CH*POS-1:0]      word_ovf;

    assign layer_ok = 32'(layer_sel) < LAYERS;
    assign s2_en    = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_en;
    assign accept   = in_valid && in_ready;

    // Nonblocking write gives read-before-write for a beat accepted in the write cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            bias_mem <= '{default: '0};
        end else if (bw_en && (32'(bw_addr) < LAYERS * CH)) begin
            bias_mem[bw_addr] <= bw_data;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_bias
        logic [AW-1:0] idx;
        assign idx = AW'(32'(layer_sel) * CH + i);
        assign bias_rd[i*DATA_LEN +: DATA_LEN] = layer_ok ? bias_mem[idx] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_d     <= '0;
            s1_bias  <= '0;
            s1_sat   <= 1'b0;
            s1_relu  <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_d    <= d;
                s1_bias <= bias_rd;
                s1_sat  <= sat_en;
                s1_relu <= relu_en;
            end
        end
    end

    for (genvar k = 0; k < CH * POS; k++) begin : g_word
        localparam int unsigned I = k / POS;
        logic [DATA_LEN:0] sum;
        assign sum = {s1_d[k*DATA_LEN+DATA_LEN-1], s1_d[k*DATA_LEN +: DATA_LEN]}
                   + {s1_bias[I*DATA_LEN+DATA_LEN-1], s1_bias[I*DATA_LEN +: DATA_LEN]};
        sat_relu_word #(
            .DATA_LEN(DATA_LEN)
        ) u_word (
            .s      (sum),
            .sat_en (s1_sat),
            .relu_en(s1_relu),
            .y      (res[k*DATA_LEN +: DATA_LEN]),
            .ovf    (word_ovf[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            q         <= '0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                q <= res;
            end
        end
    end

    // Set has priority over clear
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf     <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            if (s2_en && s1_valid && |word_ovf) begin
                ovf <= 1'b1;
            end else if (flag_clr) begin
                ovf <= 1'b0;
            end
            if (accept && !layer_ok) begin
                sel_err <= 1'b1;
            end else if (flag_clr) begin
                sel_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bias_add_pipe.sv
// Directed bench for bias_add_pipe at default parameters.
module tb_bias_add_pipe;

    localparam int unsigned DL = 18;
    localparam int unsigned CH = 32;
    localparam int unsigned POS = 12;
    localparam int unsigned LAYERS = 5;
    localparam int unsigned DW = CH * POS * DL;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    layer_sel;
    logic [DW-1:0] d;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] q;
    logic          sat_en;
    logic          relu_en;
    logic          bw_en;
    logic [7:0]    bw_addr;
    logic [DL-1:0] bw_data;
    logic          ovf;
    logic          sel_err;
    logic          flag_clr;

    int n_cmp = 0;
    int n_fail = 0;

    bias_add_pipe #(
        .DATA_LEN(DL),
        .CH      (CH),
        .POS     (POS),
        .LAYERS  (LAYERS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .layer_sel(layer_sel),
        .d        (d),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .q        (q),
        .sat_en   (sat_en),
        .relu_en  (relu_en),
        .bw_en    (bw_en),
        .bw_addr  (bw_addr),
        .bw_data  (bw_data),
        .ovf      (ovf),
        .sel_err  (sel_err),
        .flag_clr (flag_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] splat(input int v);
        logic [DW-1:0] r;
        for (int k = 0; k < int'(CH * POS); k++) r[k*DL +: DL] = DL'(v);
        return r;
    endfunction

    function automatic logic [DW-1:0] set_ch(input logic [DW-1:0] x, input int ch, input int v);
        logic [DW-1:0] r;
        r = x;
        for (int j = 0; j < int'(POS); j++) r[(ch*int'(POS)+j)*DL +: DL] = DL'(v);
        return r;
    endfunction

    function automatic logic [DW-1:0] stream_exp(input int n);
        return set_ch(set_ch(set_ch(splat(1000 + n), 0, 1200 + n), 1, 1020 + n), 2, 1007 + n);
    endfunction

    task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [DW-1:0] exp);
        int bad;
        bad = 0;
        for (int k = int'(CH * POS) - 1; k >= 0; k--) begin
            if (q[k*DL +: DL] !== exp[k*DL +: DL]) bad = k;
        end
        n_cmp++;
        assert (q === exp) else begin
            n_fail++;
            $error("FAIL %s: word %0d observed %0d expected %0d", tag, bad,
                   $signed(q[bad*DL +: DL]), $signed(exp[bad*DL +: DL]));
        end
    endtask

    initial begin
        int sent;
        int recv;
        bit acc;
        bit xfer;
        bit stalled;
        logic [DW-1:0] held_q;

        rst = 1'b1; in_valid = 1'b0; layer_sel = '0; d = '0; out_ready = 1'b1;
        sat_en = 1'b0; relu_en = 1'b0; bw_en = 1'b0; bw_addr = '0; bw_data = '0;
        flag_clr = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check1("rst_out_valid", out_valid, 0);
        check_vec("rst_q", splat(0));
        check1("rst_ovf", ovf, 0);
        check1("rst_sel_err", sel_err, 0);
        check1("rst_in_ready", in_ready, 1);

        // bias[1*CH+3] = 5, layer 1, d = 10
        bw_en = 1'b1; bw_addr = 8'(1 * CH + 3); bw_data = 18'd5;
        tick();
        bw_en = 1'b0; in_valid = 1'b1; layer_sel = 3'd1; d = splat(10);
        tick();
        in_valid = 1'b0;
        check1("lat_1cyc", out_valid, 0);
        tick();
        check1("lat_2cyc", out_valid, 1);
        check_vec("ch3_bias", set_ch(splat(10), 3, 15));
        tick();
        check1("drain_a", out_valid, 0);

        // Saturate vs wrap on channel 0 of layer 0
        bw_en = 1'b1; bw_addr = 8'd0; bw_data = 18'd200;
        tick();
        bw_en = 1'b0; in_valid = 1'b1; layer_sel = 3'd0; d = splat(131000); sat_en = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check_vec("sat_pos", set_ch(splat(131000), 0, 131071));
        check1("sat_ovf", ovf, 1);
        tick();
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        check1("ovf_clr", ovf, 0);
        in_valid = 1'b1; sat_en = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        check_vec("wrap", set_ch(splat(131000), 0, -130944));
        check1("wrap_no_ovf", ovf, 0);
        tick();

        // ReLU on channel 1 (bias 20), channel 0 still has bias 200
        bw_en = 1'b1; bw_addr = 8'd1; bw_data = 18'd20;
        tick();
        bw_en = 1'b0; in_valid = 1'b1; d = splat(-50); relu_en = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check_vec("relu_on", set_ch(splat(0), 0, 150));
        tick();
        in_valid = 1'b1; relu_en = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        check_vec("relu_off", set_ch(set_ch(splat(-50), 0, 150), 1, -30));
        tick();

        // Bias write in the same cycle as accept: old value now, new value next beat
        in_valid = 1'b1; d = splat(1); sat_en = 1'b1;
        bw_en = 1'b1; bw_addr = 8'd2; bw_data = 18'd7;
        tick();
        bw_en = 1'b0;
        tick();
        in_valid = 1'b0;
        check1("rbw_valid1", out_valid, 1);
        check_vec("rbw_old", set_ch(set_ch(set_ch(splat(1), 0, 201), 1, 21), 2, 1));
        tick();
        check1("rbw_valid2", out_valid, 1);
        check_vec("rbw_new", set_ch(set_ch(set_ch(splat(1), 0, 201), 1, 21), 2, 8));
        tick();
        check1("drain_d", out_valid, 0);

        // Out-of-range layer select
        sat_en = 1'b0; in_valid = 1'b1; layer_sel = 3'd7; d = splat(3);
        tick();
        in_valid = 1'b0; layer_sel = 3'd0;
        check1("sel_err_set", sel_err, 1);
        tick();
        check_vec("sel_bias0", splat(3));
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        check1("sel_err_clr", sel_err, 0);
        in_valid = 1'b1; layer_sel = 3'd7; flag_clr = 1'b1;
        tick();
        in_valid = 1'b0; layer_sel = 3'd0; flag_clr = 1'b0;
        check1("set_beats_clr", sel_err, 1);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        check1("sel_err_clr2", sel_err, 0);
        tick();

        // Streaming with out_ready toggling every cycle
        sent = 0; recv = 0; stalled = 1'b0; held_q = '0;
        for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
            in_valid = (sent < 8);
            d = splat(1000 + sent);
            out_ready = (cyc % 2 == 0);
            #1;
            if (stalled) begin
                check1("stall_valid", out_valid, 1);
                check_vec("stall_hold", held_q);
            end
            if (!in_ready) check1("in_ready_low", out_valid && !out_ready, 1);
            acc = in_valid && in_ready;
            xfer = out_valid && out_ready;
            if (xfer) check_vec("stream_q", stream_exp(recv));
            stalled = out_valid && !out_ready;
            held_q = q;
            tick();
            if (acc) sent++;
            if (xfer) recv++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check1("stream_count", recv, 8);
        tick();
        tick();

        // Reset with both stages full; same-cycle bias write must be ignored
        out_ready = 1'b0; in_valid = 1'b1; d = splat(5);
        tick();
        tick();
        check1("full_in_ready", in_ready, 0);
        rst = 1'b1; bw_en = 1'b1; bw_addr = 8'd0; bw_data = 18'd99;
        tick();
        rst = 1'b0; bw_en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check1("mid_rst_valid", out_valid, 0);
        check1("mid_rst_ready", in_ready, 1);
        tick();
        check1("no_stale_out", out_valid, 0);
        in_valid = 1'b1; layer_sel = 3'd0; d = splat(4);
        tick();
        in_valid = 1'b0;
        tick();
        check1("post_rst_valid", out_valid, 1);
        check_vec("bias_cleared", splat(4));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
